spi_cfg_sequencer: RTL and testbench
====================================

Name: spi_cfg_sequencer

Overview:
- Sequences the imager's SPI register configuration: walks a loadable table of (address, data) pairs and issues each pair to the shared SPI write engine, with optional read-back verification through the SPI read engine.
- Shares the one SPI pin set between both engines and a host single-register read. SpiSel drives the top-level pin mux.
- Sits between the Opal Kelly host interface and the SPI_write/SPI_read engines.

Parameters:
DEPTH, 16, number of table entries
IDX_W, 4, table index width (log2 DEPTH)
TIMEOUT, 4095, max FSM_Clk cycles to wait for an engine done before aborting the entry

Ports:
FSM_Clk  in  1  single clock for the block and both engines
Reset  in  1  asynchronous, active-high reset
Start  in  1  single-cycle pulse; begins a table pass
NumPairs  in  IDX_W+1  entries to process; values above DEPTH are clamped to DEPTH
TblWrEn  in  1  table load strobe
TblWrIdx  in  IDX_W  table load index
TblWrAddr  in  7  register address to store
TblWrData  in  8  register data to store
HostRdReq  in  1  level request for a single read
HostRdAddr  in  7  address for the host read
HostRdAck  out  1  one-cycle pulse when HostRdData is valid
HostRdData  out  8  data from the host read
WrStart  out  1  one-cycle pulse to the write engine
WrAddr  out  7  address to the write engine, held until WrDone
WrData  out  8  data to the write engine, held until WrDone
WrDone  in  1  one-cycle completion pulse from the write engine
RdStart  out  1  one-cycle pulse to the read engine
RdAddr  out  7  address to the read engine, held until RdDone
RdData  in  8  read result, valid with RdDone
RdDone  in  1  one-cycle completion pulse from the read engine
SpiSel  out  1  pin owner: 0 = write engine, 1 = read engine
Busy  out  1  high when the FSM is not in IDLE
Done  out  1  one-cycle pulse at the end of a pass
ErrCount  out  8  errors in the current pass; saturates at 255
ErrFlag  out  1  sticky; high if ErrCount is nonzero

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM goes to IDLE; index goes to 0.
  - Table contents are not reset.
- Table load:
  - A TblWrEn write takes effect on the next FSM_Clk edge.
  - Loads are accepted in any state. A load to the entry currently being issued does not change WrAddr or WrData mid-transaction.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, RB_ISSUE, RB_WAIT, NEXT, HOST_ISSUE, HOST_WAIT, FIN.
- IDLE:
  - HostRdReq has priority over Start and moves to HOST_ISSUE.
  - Otherwise Start clears ErrCount and ErrFlag, sets index to 0, and moves to WR_ISSUE. If clamped NumPairs is 0, it moves to FIN instead.
  - Start while not in IDLE is ignored.
- WR_ISSUE:
  - One cycle. WrStart=1, SpiSel=0, WrAddr/WrData = table[index].
  - Latency: Start sampled at cycle N gives WrStart at cycle N+1.
- WR_WAIT:
  - On WrDone, moves to RB_ISSUE (feature enabled) or NEXT (feature disabled).
- RB_ISSUE / RB_WAIT:
  - SpiSel switches to 1 in RB_ISSUE; RdStart pulses for one cycle with RdAddr = table[index].addr.
  - On RdDone, compares RdData to table[index].data. A mismatch increments ErrCount. Then moves to NEXT.
- NEXT:
  - One cycle. Increments index.
  - If HostRdReq is high, moves to HOST_ISSUE; the pass resumes afterward.
  - Otherwise, if index equals NumPairs, moves to FIN; else to WR_ISSUE.
- HOST_ISSUE / HOST_WAIT:
  - SpiSel=1; RdStart pulses with RdAddr = HostRdAddr.
  - On RdDone, HostRdData = RdData and HostRdAck pulses in the same cycle as the transition out.
  - Returns to IDLE if no pass is active, otherwise to WR_ISSUE or FIN per the NEXT rule.
- FIN:
  - One cycle. Done=1, then IDLE.
- Timeout:
  - A per-wait counter is cleared on entry to any *_WAIT state.
  - Reaching TIMEOUT increments ErrCount and moves to NEXT. From HOST_WAIT it instead gives HostRdAck with HostRdData=8'hFF.
- SpiSel changes only in *_ISSUE states, never during a wait.
- Done pulses that arrive outside the matching wait state are ignored.
- Reset mid-transaction aborts immediately; the engines are reset by the same Reset.

Optional Feature:
- Macro: SPI_CFG_READBACK_VERIFY_EN
- Defined: RB_ISSUE and RB_WAIT are present; each write is followed by a read-back and compare.
- Undefined: RB states are not compiled, WR_WAIT goes directly to NEXT, and ErrCount counts timeouts only.

Test Plan:
- Load 2 entries (0x3A→0x55, 0x10→0x0F), NumPairs=2, pulse Start:
  - WrStart at cycle +1 with 0x3A/0x55, then 0x10/0x0F.
  - Done pulses once; ErrCount=0.
- Verify enabled, read model returns 0x54 for 0x3A -> ErrCount=1, ErrFlag=1, Done still pulses.
- Hold HostRdReq with addr 0x20 during entry 0 WR_WAIT:
  - The host read is served after NEXT with SpiSel=1 and HostRdAck carrying the model value.
  - Entry 1 is written after it.
- Write engine never asserts WrDone, TIMEOUT=15 -> abort after 15 cycles, ErrCount=1, sequence continues to next entry.
- NumPairs=0 -> Done one cycle after FIN entry; no WrStart. NumPairs=20 with DEPTH=16 -> exactly 16 writes.
- Assert Reset during RB_WAIT -> all outputs 0 asynchronously. Then Start gives a fresh pass from index 0 with the table intact.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// Walks a loadable (address, data) table through the shared SPI write engine and serves host single-register reads.
// Optional read-back compare after each write is compiled in when SPI_CFG_READBACK_VERIFY_EN is defined.
module spi_cfg_sequencer #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic             FSM_Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IDX_W:0]   NumPairs,
    input  logic             TblWrEn,
    input  logic [IDX_W-1:0] TblWrIdx,
    input  logic [6:0]       TblWrAddr,
    input  logic [7:0]       TblWrData,
    input  logic             HostRdReq,
    input  logic [6:0]       HostRdAddr,
    output logic             HostRdAck,
    output logic [7:0]       HostRdData,
    output logic             WrStart,
    output logic [6:0]       WrAddr,
    output logic [7:0]       WrData,
    input  logic             WrDone,
    output logic             RdStart,
    output logic [6:0]       RdAddr,
    input  logic [7:0]       RdData,
    input  logic             RdDone,
    output logic             SpiSel,
    output logic             Busy,
    output logic             Done,
    output logic [7:0]       ErrCount,
    output logic             ErrFlag,
    output logic [3:0]       dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_ISSUE   = 4'd1,
        WR_WAIT    = 4'd2,
`ifdef SPI_CFG_READBACK_VERIFY_EN
        RB_ISSUE   = 4'd3,
        RB_WAIT    = 4'd4,
`endif
        NEXT       = 4'd5,
        HOST_ISSUE = 4'd6,
        HOST_WAIT  = 4'd7,
        FIN        = 4'd8
    } state_t;

    state_t           state, state_d;
    logic [IDX_W:0]   idx, idx_d, idx_inc, num_q, num_clamped;
    logic             pass_active, start_pass, err_inc, wait_st, timeout;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       host_data_q;
    logic [6:0]       tbl_addr [DEPTH];
    logic [7:0]       tbl_data [DEPTH];

    assign idx_inc     = idx + 1'b1;
    assign num_clamped = (NumPairs > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : NumPairs;
    assign timeout     = (cnt == CNT_W'(TIMEOUT - 1));
    assign WrStart     = (state == WR_ISSUE);
`ifdef SPI_CFG_READBACK_VERIFY_EN
    assign RdStart     = (state == RB_ISSUE) || (state == HOST_ISSUE);
    assign wait_st     = (state == WR_WAIT) || (state == RB_WAIT) || (state == HOST_WAIT);
`else
    assign RdStart     = (state == HOST_ISSUE);
    assign wait_st     = (state == WR_WAIT) || (state == HOST_WAIT);
`endif
    assign Busy        = (state != IDLE);
    assign Done        = (state == FIN);
    assign dbg_state   = state;

    // Table has no reset; a load lands on the next edge regardless of FSM state.
    always_ff @(posedge FSM_Clk) begin
        if (TblWrEn) begin
            tbl_addr[TblWrIdx] <= TblWrAddr;
            tbl_data[TblWrIdx] <= TblWrData;
        end
    end

    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        start_pass = 1'b0;
        err_inc    = 1'b0;
        HostRdAck  = 1'b0;
        HostRdData = host_data_q;
        case (state)
            IDLE: begin
                if (HostRdReq) begin
                    state_d = HOST_ISSUE;
                end else if (Start) begin
                    start_pass = 1'b1;
                    idx_d      = '0;
                    state_d    = (num_clamped == '0) ? FIN : WR_ISSUE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT: begin
                if (WrDone) begin
`ifdef SPI_CFG_READBACK_VERIFY_EN
                    state_d = RB_ISSUE;
`else
                    state_d = NEXT;
`endif
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = NEXT;
                end
            end
`ifdef SPI_CFG_READBACK_VERIFY_EN
            RB_ISSUE: state_d = RB_WAIT;
            RB_WAIT: begin
                // WrData still holds the entry as issued, immune to table reloads.
                if (RdDone) begin
                    err_inc = (RdData != WrData);
                    state_d = NEXT;
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = NEXT;
                end
            end
`endif
            NEXT: begin
                idx_d = idx_inc;
                if (HostRdReq)             state_d = HOST_ISSUE;
                else if (idx_inc == num_q) state_d = FIN;
                else                       state_d = WR_ISSUE;
            end
            HOST_ISSUE: state_d = HOST_WAIT;
            HOST_WAIT: begin
                if (RdDone || timeout) begin
                    HostRdAck  = 1'b1;
                    HostRdData = RdDone ? RdData : 8'hFF;
                    if (!pass_active)      state_d = IDLE;
                    else if (idx == num_q) state_d = FIN;
                    else                   state_d = WR_ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) begin
            idx         <= '0;
            num_q       <= '0;
            pass_active <= 1'b0;
            cnt         <= '0;
            WrAddr      <= '0;
            WrData      <= '0;
            RdAddr      <= '0;
            SpiSel      <= 1'b0;
            ErrCount    <= '0;
            ErrFlag     <= 1'b0;
            host_data_q <= '0;
        end else begin
            idx <= idx_d;
            if (start_pass) begin
                num_q       <= num_clamped;
                pass_active <= 1'b1;
                ErrCount    <= '0;
                ErrFlag     <= 1'b0;
            end else if (err_inc) begin
                if (ErrCount != 8'hFF) ErrCount <= ErrCount + 8'd1;
                ErrFlag <= 1'b1;
            end
            if (state == FIN) pass_active <= 1'b0;
            if (state_d != state) cnt <= '0;
            else if (wait_st)     cnt <= cnt + CNT_W'(1);
            // Issue-side registers load on entry to an ISSUE state and hold through the wait.
            if (state_d == WR_ISSUE && state != WR_ISSUE) begin
                WrAddr <= tbl_addr[idx_d[IDX_W-1:0]];
                WrData <= tbl_data[idx_d[IDX_W-1:0]];
                SpiSel <= 1'b0;
            end
`ifdef SPI_CFG_READBACK_VERIFY_EN
            if (state_d == RB_ISSUE && state != RB_ISSUE) begin
                RdAddr <= WrAddr;
                SpiSel <= 1'b1;
            end
`endif
            if (state_d == HOST_ISSUE && state != HOST_ISSUE) begin
                RdAddr <= HostRdAddr;
                SpiSel <= 1'b1;
            end
            if (HostRdAck) host_data_q <= HostRdData;
        end
    end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: vector table of table passes plus hand sequences for host reads,
// timeouts, mid-transaction loads and reset; readback cases run when SPI_CFG_READBACK_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;
    localparam int DEPTH   = 16;
    localparam int IDX_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Start = 1'b0;
    logic [IDX_W:0]   NumPairs = '0;
    logic             TblWrEn = 1'b0;
    logic [IDX_W-1:0] TblWrIdx = '0;
    logic [6:0]       TblWrAddr = '0;
    logic [7:0]       TblWrData = '0;
    logic             HostRdReq = 1'b0;
    logic [6:0]       HostRdAddr = '0;
    logic             HostRdAck;
    logic [7:0]       HostRdData;
    logic             WrStart;
    logic [6:0]       WrAddr;
    logic [7:0]       WrData;
    logic             WrDone = 1'b0;
    logic             RdStart;
    logic [6:0]       RdAddr;
    logic [7:0]       RdData = '0;
    logic             RdDone = 1'b0;
    logic             SpiSel;
    logic             Busy;
    logic             Done;
    logic [7:0]       ErrCount;
    logic             ErrFlag;
    logic [3:0]       dbg_state;

    spi_cfg_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .FSM_Clk(clk), .Reset(rst), .Start(Start), .NumPairs(NumPairs),
        .TblWrEn(TblWrEn), .TblWrIdx(TblWrIdx), .TblWrAddr(TblWrAddr), .TblWrData(TblWrData),
        .HostRdReq(HostRdReq), .HostRdAddr(HostRdAddr), .HostRdAck(HostRdAck), .HostRdData(HostRdData),
        .WrStart(WrStart), .WrAddr(WrAddr), .WrData(WrData), .WrDone(WrDone),
        .RdStart(RdStart), .RdAddr(RdAddr), .RdData(RdData), .RdDone(RdDone),
        .SpiSel(SpiSel), .Busy(Busy), .Done(Done), .ErrCount(ErrCount), .ErrFlag(ErrFlag),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q[$];
    int          wr_cyc_q[$];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          ack_cnt = 0;
    int          ack_wr_cnt = 0;
    logic [7:0]  last_ack_data = '0;
    bit          hang_once = 1'b0;
    bit          bad_en = 1'b0;
    logic [6:0]  bad_addr = '0;
    logic [7:0]  bad_val = '0;
    logic [7:0]  regs [128];
    logic [6:0]  tm_addr [DEPTH];
    logic [7:0]  tm_data [DEPTH];

    typedef struct {
        int num;
        int writes;
        int errs;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // write engine model + scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (WrStart) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                chk("wr_spisel", 64'(SpiSel), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%0h required=none", {WrAddr, WrData});
                end else begin
                    chk("wr_pair", 64'({WrAddr, WrData}), 64'(exp_q.pop_front()));
                end
                regs[WrAddr] = WrData;
                if (hang_once) begin
                    hang_once = 1'b0;
                end else begin
                    repeat (3) @(posedge clk);
                    #1 WrDone = 1'b1;
                    @(posedge clk);
                    #1 WrDone = 1'b0;
                end
            end
        end
    end

    // read engine model
    initial begin
        logic [6:0] a;
        forever begin
            @(negedge clk);
            if (RdStart) begin
                chk("rd_spisel", 64'(SpiSel), 64'd1);
                a = RdAddr;
                repeat (2) @(posedge clk);
                #1 RdData = (bad_en && a == bad_addr) ? bad_val : regs[a];
                RdDone = 1'b1;
                @(posedge clk);
                #1 RdDone = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (Done) done_cnt++;
            if (HostRdAck) begin
                ack_cnt++;
                last_ack_data = HostRdData;
                ack_wr_cnt = wr_cnt;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [6:0] a, input logic [7:0] d);
        @(posedge clk);
        #1 TblWrEn = 1'b1;
        TblWrIdx  = idx[IDX_W-1:0];
        TblWrAddr = a;
        TblWrData = d;
        @(posedge clk);
        #1 TblWrEn = 1'b0;
        tm_addr[idx] = a;
        tm_data[idx] = d;
    endtask

    task automatic expect_pass(input int num);
        for (int i = 0; i < num && i < DEPTH; i++) exp_q.push_back({tm_addr[i], tm_data[i]});
    endtask

    task automatic pulse_start(input int num);
        @(posedge clk);
        #1 NumPairs = (IDX_W+1)'(num);
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int i = 0;
        while (i < bound && !(done_cnt > 0 && !Busy)) begin
            @(negedge clk);
            i++;
        end
        if (i >= bound) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_ack(input int bound);
        int i = 0;
        while (i < bound && ack_cnt == 0) begin
            @(negedge clk);
            i++;
        end
        if (i >= bound) begin
            checks++;
            errors++;
            $display("FAIL host_ack_timeout actual=none required=HostRdAck within %0d cycles", bound);
        end
    endtask

    task automatic run_pass(input int num, input int writes, input int errs);
        int wr0;
        exp_q.delete();
        wr0 = wr_cnt;
        done_cnt = 0;
        expect_pass(num);
        pulse_start(num);
        @(negedge clk);
        chk("start_latency_wrstart", 64'(WrStart), 64'(writes != 0));
        chk("start_latency_done", 64'(Done), 64'(writes == 0));
        wait_idle(400, "pass");
        tick(2);
        chk("pass_writes", 64'(wr_cnt - wr0), 64'(writes));
        chk("pass_done_count", 64'(done_cnt), 64'd1);
        chk("pass_errcount", 64'(ErrCount), 64'(errs));
        chk("pass_errflag", 64'(ErrFlag), 64'(errs != 0));
        chk("pass_exp_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] old_a;
        logic [7:0] old_d;
        int wr0;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        regs[7'h20] = 8'hA7;
        vecs[0] = '{2, 2, 0};
        vecs[1] = '{1, 1, 0};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{5, 5, 0};
        vecs[4] = '{16, 16, 0};
        vecs[5] = '{20, 16, 0};
        vecs[6] = '{31, 16, 0};

        tick(3);
        chk("reset_outputs", 64'({HostRdAck, HostRdData, WrStart, WrAddr, WrData, RdStart, RdAddr,
                                  SpiSel, Busy, Done, ErrCount, ErrFlag}), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        load(0, 7'h3A, 8'h55);
        load(1, 7'h10, 8'h0F);
        for (int i = 2; i < DEPTH; i++) load(i, 7'(64 + i), 8'(192 + i));

        for (int v = 0; v < 7; v++) run_pass(vecs[v].num, vecs[v].writes, vecs[v].errs);

`ifdef SPI_CFG_READBACK_VERIFY_EN
        bad_en = 1'b1;
        bad_addr = 7'h3A;
        bad_val = 8'h54;
        run_pass(2, 2, 1);
        bad_en = 1'b0;
`endif

        // host read raised during entry 0 write wait
        exp_q.delete();
        expect_pass(2);
        done_cnt = 0;
        ack_cnt = 0;
        wr0 = wr_cnt;
        pulse_start(2);
        @(posedge clk);
        #1 HostRdReq = 1'b1;
        HostRdAddr = 7'h20;
        wait_ack(100);
        @(posedge clk);
        #1 HostRdReq = 1'b0;
        wait_idle(200, "host_pass");
        tick(2);
        chk("host_ack_data", 64'(last_ack_data), 64'hA7);
        chk("host_ack_after_entry0", 64'(ack_wr_cnt - wr0), 64'd1);
        chk("host_ack_count", 64'(ack_cnt), 64'd1);
        chk("host_pass_writes", 64'(wr_cnt - wr0), 64'd2);
        chk("host_pass_done", 64'(done_cnt), 64'd1);
        chk("host_pass_exp_q_empty", 64'(exp_q.size()), 64'd0);

        // host read from idle wins over a simultaneous Start
        ack_cnt = 0;
        done_cnt = 0;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 HostRdReq = 1'b1;
        HostRdAddr = 7'h3A;
        Start = 1'b1;
        NumPairs = 5'd2;
        @(posedge clk);
        #1 Start = 1'b0;
        wait_ack(50);
        @(posedge clk);
        #1 HostRdReq = 1'b0;
        tick(20);
        chk("idle_host_data", 64'(last_ack_data), 64'h55);
        chk("idle_host_no_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("idle_host_no_done", 64'(done_cnt), 64'd0);
        chk("idle_host_busy", 64'(Busy), 64'd0);

        // write engine hangs on entry 0
        wr_cyc_q.delete();
        hang_once = 1'b1;
        run_pass(2, 2, 1);
        if (wr_cyc_q.size() == 2) begin
            chk("timeout_gap", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'(TIMEOUT + 2));
        end else begin
            checks++;
            errors++;
            $display("FAIL timeout_writes actual=%0d required=2", wr_cyc_q.size());
        end

        // table load to the entry in flight leaves WrAddr/WrData alone
        exp_q.delete();
        expect_pass(1);
        done_cnt = 0;
        wr0 = wr_cnt;
        old_a = tm_addr[0];
        old_d = tm_data[0];
        pulse_start(1);
        load(0, 7'h11, 8'h22);
        @(negedge clk);
        chk("load_inflight_wraddr", 64'(WrAddr), 64'(old_a));
        chk("load_inflight_wrdata", 64'(WrData), 64'(old_d));
        wait_idle(100, "load_pass");
        chk("load_inflight_writes", 64'(wr_cnt - wr0), 64'd1);

        // asynchronous reset mid-transaction, then a fresh pass
        exp_q.delete();
        expect_pass(2);
        pulse_start(2);
`ifdef SPI_CFG_READBACK_VERIFY_EN
        begin
            int i = 0;
            while (i < 50 && !RdStart) begin
                @(negedge clk);
                i++;
            end
        end
        @(posedge clk);
`else
        @(posedge clk);
`endif
        #3;
        chk("pre_reset_busy", 64'(Busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({HostRdAck, HostRdData, WrStart, WrAddr, WrData, RdStart, RdAddr,
                                        SpiSel, Busy, Done, ErrCount, ErrFlag}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(10);
        run_pass(2, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
